// File: rtl/axi_rd_arbiter_pkg.sv
// Shared types and constants for the AXI4 read-channel arbiter and its
// round-robin helper.
package axi_rd_arbiter_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

  // Widest fields carried by the request/response records.
  localparam int AXI_ADDR_W_MAX = 64;
  localparam int AXI_DATA_W_MAX = 64;
  localparam int AXI_LEN_W      = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } ArbState;

  typedef struct packed {
    logic [AXI_ADDR_W_MAX-1:0] addr;
    logic [AXI_LEN_W-1:0]      len;
    logic [2:0]                size;
    logic                      valid;
  } AxiRdReqSt;

  typedef struct packed {
    logic [AXI_DATA_W_MAX-1:0] data;
    logic                      last;
    logic [1:0]                resp;
    logic                      valid;
  } AxiRdRspSt;

endpackage

// File: rtl/axi_rd_arbiter_rr.sv
// Combinational round-robin picker: first requester at or after i_ptr,
// wrapping to the lowest index when none are found above the pointer.
module rr_arbiter #(
  parameter int REQ_NUM = 2
) (
  input  logic [REQ_NUM-1:0]         i_req,
  input  logic [$clog2(REQ_NUM)-1:0] i_ptr,
  output logic [REQ_NUM-1:0]         o_grant,
  output logic                       o_valid
);

  logic [REQ_NUM-1:0] w_upper;
  logic [REQ_NUM-1:0] w_masked;
  logic [REQ_NUM-1:0] w_pick;

  always_comb begin
    w_upper = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      w_upper[i] = (i >= int'(i_ptr));
    end
    w_masked = i_req & w_upper;
    // Fall back to the unmasked vector when nothing sits at/after the pointer.
    w_pick   = (w_masked != '0) ? w_masked : i_req;
    o_grant  = '0;
    for (int i = REQ_NUM - 1; i >= 0; i--) begin
      if (w_pick[i]) begin
        o_grant    = '0;
        o_grant[i] = 1'b1;
      end
    end
    o_valid = |i_req;
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI4 AR/R channel between REQ_NUM refill requesters, one burst
// in flight, round-robin between bursts.
// Handshakes: a transfer happens on any edge where valid and ready are both
// high; valid never waits on ready, and the owner of a burst keeps the grant
// until the R beat carrying r_last is accepted.
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter int REQ_NUM    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int ID_WIDTH   = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [REQ_NUM-1:0]              req_ar_valid,
  input  logic [REQ_NUM*ADDR_WIDTH-1:0]   req_ar_addr,
  input  logic [REQ_NUM*LEN_WIDTH-1:0]    req_ar_len,
  input  logic [REQ_NUM*3-1:0]            req_ar_size,
  output logic [REQ_NUM-1:0]              req_ar_ready,
  output logic [REQ_NUM-1:0]              req_r_valid,
  input  logic [REQ_NUM-1:0]              req_r_ready,
  output logic [DATA_WIDTH-1:0]           req_r_data,
  output logic                            req_r_last,
  output logic [1:0]                      req_r_resp,
  output logic                            ar_valid,
  input  logic                            ar_ready,
  output logic [ADDR_WIDTH-1:0]           ar_addr,
  output logic [LEN_WIDTH-1:0]            ar_len,
  output logic [2:0]                      ar_size,
  output logic [1:0]                      ar_burst,
  output logic [ID_WIDTH-1:0]             ar_id,
  input  logic                            r_valid,
  output logic                            r_ready,
  input  logic [DATA_WIDTH-1:0]           r_data,
  input  logic                            r_last,
  input  logic [1:0]                      r_resp,
  input  logic [ID_WIDTH-1:0]             r_id,
  output logic                            busy,
  output logic                            id_err,
  output logic [1:0]                      dbg_state
);

  localparam int IDX_W = $clog2(REQ_NUM);

  ArbState               r_state;
  ArbState               w_state_nxt;
  logic [IDX_W-1:0]      r_rr_ptr;
  logic [IDX_W-1:0]      r_grant;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [2:0]            r_size;
  logic                  r_id_err;

  logic [REQ_NUM-1:0]    w_grant_oh;
  logic                  w_grant_vld;
  logic [IDX_W-1:0]      w_grant_idx;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [LEN_WIDTH-1:0]  w_sel_len;
  logic [2:0]            w_sel_size;
  logic [IDX_W-1:0]      w_ptr_nxt;
  logic                  w_r_done;

  rr_arbiter #(.REQ_NUM(REQ_NUM)) u_rr (
    .i_req   (req_ar_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant_oh),
    .o_valid (w_grant_vld)
  );

  always_comb begin
    w_grant_idx = '0;
    w_sel_addr  = '0;
    w_sel_len   = '0;
    w_sel_size  = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (w_grant_oh[i]) begin
        w_grant_idx = IDX_W'(i);
        w_sel_addr  = req_ar_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_len   = req_ar_len[i*LEN_WIDTH +: LEN_WIDTH];
        w_sel_size  = req_ar_size[i*3 +: 3];
      end
    end
  end

  assign w_ptr_nxt = (r_grant == IDX_W'(REQ_NUM - 1)) ? '0 : r_grant + IDX_W'(1);
  assign w_r_done  = r_valid && req_r_ready[r_grant] && r_last;

  always_comb begin
    w_state_nxt  = r_state;
    ar_valid     = 1'b0;
    r_ready      = 1'b0;
    req_ar_ready = '0;
    req_r_valid  = '0;
    case (r_state)
      IDLE: begin
        if (w_grant_vld) w_state_nxt = ADDR;
      end
      ADDR: begin
        ar_valid = 1'b1;
        if (ar_ready) begin
          req_ar_ready[r_grant] = 1'b1;
          w_state_nxt           = DATA;
        end
      end
      DATA: begin
        // Beats follow the latched grant; r_id is only checked, never used to steer.
        req_r_valid[r_grant] = r_valid;
        r_ready              = req_r_ready[r_grant];
        if (w_r_done) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_rr_ptr <= '0;
      r_grant  <= '0;
      r_addr   <= '0;
      r_len    <= '0;
      r_size   <= '0;
      r_id_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && w_grant_vld) begin
        r_grant <= w_grant_idx;
        r_addr  <= w_sel_addr;
        r_len   <= w_sel_len;
        r_size  <= w_sel_size;
      end
      if (r_state == DATA && w_r_done) r_rr_ptr <= w_ptr_nxt;
      if (r_state == DATA && r_valid && (r_id != ID_WIDTH'(r_grant))) r_id_err <= 1'b1;
    end
  end

  assign ar_addr    = r_addr;
  assign ar_len     = r_len;
  assign ar_size    = r_size;
  assign ar_burst   = AXI_BURST_INCR;
  assign ar_id      = ID_WIDTH'(r_grant);
  assign req_r_data = r_data;
  assign req_r_last = r_last;
  assign req_r_resp = r_resp;
  assign busy       = (r_state != IDLE);
  assign id_err     = r_id_err;
  assign dbg_state  = r_state;

endmodule
